// File: rtl/unoxt_loader_pkg.sv
// ============================================================================
// Package     : unoxt_loader_pkg
// Description : Shared FSM state encoding and SPI flash opcode for the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unoxt_loader_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_SETUP = 4'd1,
        ST_CMD      = 4'd2,
        ST_DATA     = 4'd3,
        ST_WR_SETUP = 4'd4,
        ST_WR_PULSE = 4'd5,
        ST_WR_HOLD  = 4'd6,
        ST_FINISH   = 4'd7,
        ST_DONE     = 4'd8
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_byte_shifter.sv
// ============================================================================
// Module      : spi_byte_shifter
// Description : SPI mode-0 engine: SCLK divider plus 8/32-bit MSB-first shifter
//               with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_shifter #(
    parameter int SCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_cmd,
    input  logic [31:0] i_tx,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_rx
);

    localparam logic [15:0] c_DIV_LAST = 16'(SCLK_DIV - 1);

    logic        r_busy_q, w_busy_d;
    logic        r_sclk_q, w_sclk_d;
    logic [15:0] r_div_q,  w_div_d;
    logic [5:0]  r_bit_q,  w_bit_d;
    logic [5:0]  r_last_q, w_last_d;
    logic [31:0] r_sh_q,   w_sh_d;
    logic [7:0]  r_rx_q,   w_rx_d;
    logic        w_tick;
    logic        w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q <= 1'b0;
            r_sclk_q <= 1'b0;
            r_div_q  <= '0;
            r_bit_q  <= '0;
            r_last_q <= '0;
            r_sh_q   <= '1;
            r_rx_q   <= '0;
        end else begin
            r_busy_q <= w_busy_d;
            r_sclk_q <= w_sclk_d;
            r_div_q  <= w_div_d;
            r_bit_q  <= w_bit_d;
            r_last_q <= w_last_d;
            r_sh_q   <= w_sh_d;
            r_rx_q   <= w_rx_d;
        end
    end

    always_comb begin
        w_busy_d = r_busy_q;
        w_sclk_d = r_sclk_q;
        w_div_d  = r_div_q;
        w_bit_d  = r_bit_q;
        w_last_d = r_last_q;
        w_sh_d   = r_sh_q;
        w_rx_d   = r_rx_q;
        w_tick   = r_busy_q && (r_div_q == c_DIV_LAST);
        w_done   = w_tick && r_sclk_q && (r_bit_q == r_last_q);

        if (r_busy_q) begin
            w_div_d = w_tick ? 16'd0 : r_div_q + 16'd1;
            if (w_tick) begin
                w_sclk_d = ~r_sclk_q;
                // Rising edge samples MISO; falling edge advances MOSI (mode 0).
                if (!r_sclk_q) begin
                    w_rx_d = {r_rx_q[6:0], i_miso};
                end else begin
                    w_sh_d  = {r_sh_q[30:0], 1'b1};
                    w_bit_d = r_bit_q + 6'd1;
                end
            end
        end

        if (w_done) begin
            w_busy_d = 1'b0;
        end

        // A start coinciding with done reloads seamlessly so CS bursts have no gaps.
        if (i_start && (!r_busy_q || w_done)) begin
            w_busy_d = 1'b1;
            w_sclk_d = 1'b0;
            w_div_d  = '0;
            w_bit_d  = '0;
            w_sh_d   = i_tx;
            w_last_d = i_cmd ? 6'd31 : 6'd7;
        end
    end

    assign o_sclk = r_sclk_q;
    assign o_mosi = r_sh_q[31];
    assign o_busy = r_busy_q;
    assign o_done = w_done;
    assign o_rx   = r_rx_q;

endmodule

`default_nettype wire

// File: rtl/spi_flash_sram_loader.sv
// ============================================================================
// Module      : spi_flash_sram_loader
// Description : Boot copier streaming LENGTH bytes from SPI flash into SRAM while
//               holding the system in reset, then handing the SRAM bus over.
//               Optional macro LOADER_CHECKSUM_EN enables the byte-sum output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_sram_loader
    import unoxt_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_START = 24'h0A0000,
    parameter logic [20:0] SRAM_START  = 21'h0F0000,
    parameter logic [16:0] LENGTH      = 17'h10000,
    parameter int          SCLK_DIV    = 2,
    parameter int          WE_CYCLES   = 2
) (
    input  logic        clk_chipset,
    input  logic        reset,
    output logic        flash_cs_n_o,
    output logic        flash_sclk_o,
    output logic        flash_mosi_o,
    input  logic        flash_miso_i,
    output logic        sys_reset,
    output logic        done,
    input  logic [20:0] sys_sram_addr,
    input  logic [7:0]  sys_sram_dout,
    input  logic        sys_sram_oe,
    input  logic        sys_sram_we_n,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_oe,
    output logic        sram_we_n,
    output logic [15:0] checksum
);

    localparam logic [15:0] c_DIV_LAST = 16'(SCLK_DIV - 1);
    localparam logic [15:0] c_WE_LAST  = 16'(WE_CYCLES - 1);
    localparam logic [16:0] c_LAST_IDX = LENGTH - 17'd1;

    loader_state_e r_state_q, w_state_d;
    logic [15:0]   r_wait_q,  w_wait_d;
    logic [16:0]   r_byte_q,  w_byte_d;
    logic [7:0]    r_data_q,  w_data_d;
    logic          w_sh_start;
    logic          w_sh_cmd;
    logic          w_sh_busy;
    logic          w_sh_done;
    logic [7:0]    w_sh_rx;
    logic [31:0]   w_sh_tx;
    logic          w_ldr_wr;

    spi_byte_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk     (clk_chipset),
        .rst     (reset),
        .i_start (w_sh_start),
        .i_cmd   (w_sh_cmd),
        .i_tx    (w_sh_tx),
        .i_miso  (flash_miso_i),
        .o_sclk  (flash_sclk_o),
        .o_mosi  (flash_mosi_o),
        .o_busy  (w_sh_busy),
        .o_done  (w_sh_done),
        .o_rx    (w_sh_rx)
    );

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_wait_q  <= '0;
            r_byte_q  <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wait_q  <= w_wait_d;
            r_byte_q  <= w_byte_d;
            r_data_q  <= w_data_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_wait_d   = r_wait_q;
        w_byte_d   = r_byte_q;
        w_data_d   = r_data_q;
        w_sh_start = 1'b0;
        w_sh_cmd   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_wait_d = '0;
                if (LENGTH == 17'd0) begin
                    w_state_d = ST_DONE;
                end else if (!w_sh_busy) begin
                    w_state_d = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (r_wait_q == c_DIV_LAST) begin
                    w_wait_d   = '0;
                    w_state_d  = ST_CMD;
                    w_sh_start = 1'b1;
                    w_sh_cmd   = 1'b1;
                end else begin
                    w_wait_d = r_wait_q + 16'd1;
                end
            end
            ST_CMD: begin
                if (w_sh_done) begin
                    w_state_d  = ST_DATA;
                    w_sh_start = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_sh_done) begin
                    w_state_d = ST_WR_SETUP;
                    w_data_d  = w_sh_rx;
                end
            end
            ST_WR_SETUP: begin
                w_wait_d  = '0;
                w_state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (r_wait_q == c_WE_LAST) begin
                    w_wait_d  = '0;
                    w_state_d = ST_WR_HOLD;
                end else begin
                    w_wait_d = r_wait_q + 16'd1;
                end
            end
            ST_WR_HOLD: begin
                if (r_byte_q == c_LAST_IDX) begin
                    w_wait_d  = '0;
                    w_state_d = ST_FINISH;
                end else begin
                    w_byte_d   = r_byte_q + 17'd1;
                    w_state_d  = ST_DATA;
                    w_sh_start = 1'b1;
                end
            end
            ST_FINISH: begin
                if (r_wait_q == c_DIV_LAST) begin
                    w_wait_d  = '0;
                    w_state_d = ST_DONE;
                end else begin
                    w_wait_d = r_wait_q + 16'd1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Data-phase transmit pattern keeps MOSI parked high while reading.
    assign w_sh_tx = w_sh_cmd ? {SPI_CMD_READ, FLASH_START} : 32'hFFFF_FFFF;

    assign w_ldr_wr     = (r_state_q == ST_WR_SETUP) || (r_state_q == ST_WR_PULSE) ||
                          (r_state_q == ST_WR_HOLD);
    assign flash_cs_n_o = (r_state_q == ST_IDLE) || (r_state_q == ST_FINISH) ||
                          (r_state_q == ST_DONE);
    assign done         = (r_state_q == ST_DONE);
    assign sys_reset    = ~done;

    assign sram_addr = done ? sys_sram_addr : SRAM_START + {4'b0000, r_byte_q};
    assign sram_dout = done ? sys_sram_dout : r_data_q;
    assign sram_oe   = done ? sys_sram_oe   : w_ldr_wr;
    assign sram_we_n = done ? sys_sram_we_n : (r_state_q != ST_WR_PULSE);

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] r_csum_q, w_csum_d;

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            r_csum_q <= '0;
        end else begin
            r_csum_q <= w_csum_d;
        end
    end

    always_comb begin
        w_csum_d = r_csum_q;
        if (r_state_q == ST_WR_SETUP) begin
            w_csum_d = r_csum_q + {8'h00, r_data_q};
        end
    end

    assign checksum = r_csum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_sram_loader.sv
// ============================================================================
// Module      : tb_spi_flash_sram_loader
// Description : Scoreboard bench with a behavioural SPI flash; also covers the
//               zero-length build and post-boot bus hand-over.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_sram_loader;

    localparam logic [23:0] FS   = 24'h0A0000;
    localparam logic [20:0] SS   = 21'h1FFFFE;
    localparam int          LEN  = 5;
    localparam int          DIV  = 2;
    localparam int          WEC  = 2;
    localparam int          PER  = 16 * DIV + WEC + 2;

    typedef struct {
        logic [20:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic [20:0] sys_addr;
    logic [7:0]  sys_dout;
    logic        sys_oe;
    logic        sys_we_n;

    logic        a_cs_n, a_sclk, a_mosi, a_miso, a_sys_reset, a_done;
    logic [20:0] a_addr;
    logic [7:0]  a_dout;
    logic        a_oe, a_we_n;
    logic [15:0] a_csum;

    logic        z_cs_n, z_sclk, z_mosi, z_sys_reset, z_done;
    logic [20:0] z_addr;
    logic [7:0]  z_dout;
    logic        z_oe, z_we_n;
    logic [15:0] z_csum;
    logic        z_miso;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_idx = 0;
    int last_cyc = 0;
    int z_cs_low = 0;
    logic prev_we = 1'b1;
    logic started = 1'b0;

    logic [7:0]  fmem [16];
    logic [31:0] f_cmd = '0;
    int          f_rcnt = 0;
    wr_t         exp_q[$];

    spi_flash_sram_loader #(
        .FLASH_START (FS),
        .SRAM_START  (SS),
        .LENGTH      (17'(LEN)),
        .SCLK_DIV    (DIV),
        .WE_CYCLES   (WEC)
    ) u_dut (
        .clk_chipset   (clk),
        .reset         (rst),
        .flash_cs_n_o  (a_cs_n),
        .flash_sclk_o  (a_sclk),
        .flash_mosi_o  (a_mosi),
        .flash_miso_i  (a_miso),
        .sys_reset     (a_sys_reset),
        .done          (a_done),
        .sys_sram_addr (sys_addr),
        .sys_sram_dout (sys_dout),
        .sys_sram_oe   (sys_oe),
        .sys_sram_we_n (sys_we_n),
        .sram_addr     (a_addr),
        .sram_dout     (a_dout),
        .sram_oe       (a_oe),
        .sram_we_n     (a_we_n),
        .checksum      (a_csum)
    );

    spi_flash_sram_loader #(
        .LENGTH (17'd0)
    ) u_dut_zero (
        .clk_chipset   (clk),
        .reset         (rst),
        .flash_cs_n_o  (z_cs_n),
        .flash_sclk_o  (z_sclk),
        .flash_mosi_o  (z_mosi),
        .flash_miso_i  (z_miso),
        .sys_reset     (z_sys_reset),
        .done          (z_done),
        .sys_sram_addr (sys_addr),
        .sys_sram_dout (sys_dout),
        .sys_sram_oe   (sys_oe),
        .sys_sram_we_n (sys_we_n),
        .sram_addr     (z_addr),
        .sram_dout     (z_dout),
        .sram_oe       (z_oe),
        .sram_we_n     (z_we_n),
        .checksum      (z_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign z_miso = 1'b0;

    // Behavioural flash: captures a 32-bit command, then streams fmem from offset 0.
    initial a_miso = 1'b0;
    always @(posedge a_sclk or posedge a_cs_n) begin
        if (a_cs_n) begin
            f_rcnt = 0;
        end else begin
            if (f_rcnt < 32) f_cmd = {f_cmd[30:0], a_mosi};
            f_rcnt++;
        end
    end
    always @(negedge a_sclk) begin
        if (!a_cs_n && f_rcnt >= 32) begin
            int k;
            k = f_rcnt - 32;
            a_miso = fmem[(k / 8) % 16][7 - (k % 8)];
        end
    end

    always @(negedge z_cs_n) if (started) z_cs_low++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: each loader WE falling edge must match the next expected write.
    always @(negedge clk) begin
        if (!rst && !a_done && a_we_n == 1'b0 && prev_we == 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {11'd0, a_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {11'd0, a_addr}, {11'd0, e.addr});
                chk("wr_data", {24'd0, a_dout}, {24'd0, e.data});
                chk("wr_oe", {31'd0, a_oe}, 32'd1);
                if (wr_idx > 0) chk("byte_period", cyc - last_cyc, PER);
                last_cyc = cyc;
                wr_idx++;
            end
        end
        prev_we = a_we_n;
    end

    task automatic push_expected();
        exp_q.delete();
        wr_idx = 0;
        for (int i = 0; i < LEN; i++) begin
            wr_t e;
            e.addr = 21'((32'(SS) + i) % (1 << 21));
            e.data = fmem[i];
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [15:0] model_csum();
        int s;
        s = 0;
`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < LEN; i++) s = (s + fmem[i]) % 65536;
`endif
        return 16'(s);
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_cs_n"}, {31'd0, a_cs_n}, 32'd1);
        chk({tag, "_sclk"}, {31'd0, a_sclk}, 32'd0);
        chk({tag, "_mosi"}, {31'd0, a_mosi}, 32'd1);
        chk({tag, "_sys_reset"}, {31'd0, a_sys_reset}, 32'd1);
        chk({tag, "_done"}, {31'd0, a_done}, 32'd0);
        chk({tag, "_we_n"}, {31'd0, a_we_n}, 32'd1);
        chk({tag, "_oe"}, {31'd0, a_oe}, 32'd0);
        chk({tag, "_addr"}, {11'd0, a_addr}, {11'd0, SS});
        chk({tag, "_csum"}, {16'd0, a_csum}, 32'd0);
    endtask

    task automatic wait_done_and_check(input string tag);
        for (int i = 0; i < 3000 && !a_done; i++) @(posedge clk);
        #1;
        chk({tag, "_done"}, {31'd0, a_done}, 32'd1);
        chk({tag, "_sys_reset"}, {31'd0, a_sys_reset}, 32'd0);
        chk({tag, "_cs_n"}, {31'd0, a_cs_n}, 32'd1);
        chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        chk({tag, "_cmd"}, f_cmd, {8'h03, FS});
        chk({tag, "_csum"}, {16'd0, a_csum}, {16'd0, model_csum()});
    endtask

    initial begin
        rst      = 1'b1;
        sys_addr = '0;
        sys_dout = '0;
        sys_oe   = 1'b0;
        sys_we_n = 1'b1;
        for (int i = 0; i < 16; i++) fmem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        check_reset_state("rst");
        chk("z_rst_done", {31'd0, z_done}, 32'd0);
        chk("z_rst_addr", {11'd0, z_addr}, 32'h0F0000);

        // Pass 1: random flash content, wrapping SRAM address.
        push_expected();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("z_done", {31'd0, z_done}, 32'd1);
        chk("z_sys_reset", {31'd0, z_sys_reset}, 32'd0);
        wait_done_and_check("p1");

        // Pass 2: FF,FF,02,... with a reset pulse after the second byte.
        fmem[0] = 8'hFF; fmem[1] = 8'hFF; fmem[2] = 8'h02; fmem[3] = 8'h00; fmem[4] = 8'h00;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("p2rst");
        push_expected();
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 1000 && wr_idx < 2; i++) @(posedge clk);
        chk("p2_two_writes", wr_idx, 32'd2);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cs_n", {31'd0, a_cs_n}, 32'd1);
        chk("mid_rst_sclk", {31'd0, a_sclk}, 32'd0);
        chk("mid_rst_addr", {11'd0, a_addr}, {11'd0, SS});
        push_expected();
        @(posedge clk); #2 rst = 1'b0;
        wait_done_and_check("p2");
        chk("p2_restart_writes", wr_idx, LEN);

        // Bus hand-over after boot is purely combinational.
        sys_addr = 21'h12345; sys_we_n = 1'b0; sys_oe = 1'b1; sys_dout = 8'($urandom);
        #1;
        chk("mux_addr", {11'd0, a_addr}, 32'h12345);
        chk("mux_we_n", {31'd0, a_we_n}, 32'd0);
        chk("mux_oe", {31'd0, a_oe}, 32'd1);
        chk("mux_dout", {24'd0, a_dout}, {24'd0, sys_dout});
        for (int i = 0; i < 4; i++) begin
            sys_addr = 21'($urandom); sys_we_n = 1'($urandom); sys_oe = 1'($urandom);
            sys_dout = 8'($urandom);
            #1;
            chk("mux_rand_addr", {11'd0, a_addr}, {11'd0, sys_addr});
            chk("mux_rand_we_n", {31'd0, a_we_n}, {31'd0, sys_we_n});
            chk("z_mux_addr", {11'd0, z_addr}, {11'd0, sys_addr});
            @(negedge clk);
        end
        chk("z_cs_never_low", z_cs_low, 32'd0);
        chk("z_csum", {16'd0, z_csum}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
